// File: rtl/video_pkg.sv
// Shared video geometry for the framebuffer and its scan-out stage, so that the RAM depth
// and the scan-out counters are derived from the same numbers.
package video_pkg;

  localparam int VID_FB_W       = 160;
  localparam int VID_FB_H       = 120;
  localparam int VID_H_SCALE    = 8;
  localparam int VID_V_SCALE    = 6;
  localparam int VID_ADDR_WIDTH = 15;
  localparam int VID_FB_DEPTH   = VID_FB_W * VID_FB_H;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  // Width needed to hold the values 0..n-1 (never less than one bit).
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Bit replication keeps full-scale codes at 0 and 255.
  function automatic rgb888_t expand332(input logic [7:0] d);
    rgb888_t p;
    p.r = {d[7:5], d[7:5], d[7:6]};
    p.g = {d[4:2], d[4:2], d[4:3]};
    p.b = {4{d[1:0]}};
    return p;
  endfunction

endpackage

// File: rtl/rgb332_expand.sv
// Registered RGB332 to RGB888 expansion; the pixel is forced to black when not enabled.
module rgb332_expand
  import video_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_i,
  input  logic       en_i,
  output logic [7:0] r_o,
  output logic [7:0] g_o,
  output logic [7:0] b_o
);

  rgb888_t pix_d;
  rgb888_t pix_q;

  always_comb begin
    pix_d = '0;
    if (en_i) pix_d = expand332(data_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pix_q <= '0;
    else        pix_q <= pix_d;
  end

  assign r_o = pix_q.r;
  assign g_o = pix_q.g;
  assign b_o = pix_q.b;

endmodule

// File: rtl/fb_scanout.sv
// Framebuffer scan-out: turns video timing into pixel-replicated read addresses and
// re-aligns the returned RGB332 data, expanded to RGB888, with the delayed sync/DE.
module fb_scanout
  import video_pkg::*;
#(
  parameter int   ADDR_WIDTH = VID_ADDR_WIDTH,
  parameter int   FB_W       = VID_FB_W,
  parameter int   FB_H       = VID_FB_H,
  parameter int   H_SCALE    = VID_H_SCALE,
  parameter int   V_SCALE    = VID_V_SCALE,
  parameter logic VS_ACTIVE  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  vid_de,
  input  logic                  vid_hs,
  input  logic                  vid_vs,
  output logic                  fb_rd_en,
  output logic [ADDR_WIDTH-1:0] fb_rd_addr,
  input  logic [7:0]            fb_rd_data,
  output logic                  out_de,
  output logic                  out_hs,
  output logic                  out_vs,
  output logic [7:0]            out_r,
  output logic [7:0]            out_g,
  output logic [7:0]            out_b
);

  localparam int HW = cnt_w(H_SCALE);
  localparam int XW = cnt_w(FB_W + 1);
  localparam int VW = cnt_w(V_SCALE);
  localparam int YW = cnt_w(FB_H + 1);

  localparam logic [HW-1:0]         H_LAST  = HW'(H_SCALE - 1);
  localparam logic [VW-1:0]         V_LAST  = VW'(V_SCALE - 1);
  localparam logic [XW-1:0]         X_END   = XW'(FB_W);
  localparam logic [YW-1:0]         Y_END   = YW'(FB_H);
  localparam logic [ADDR_WIDTH-1:0] ROW_INC = ADDR_WIDTH'(FB_W);

  logic [HW-1:0]         h_sub_q, h_sub_d;
  logic [XW-1:0]         fb_x_q, fb_x_d;
  logic [VW-1:0]         v_sub_q, v_sub_d;
  logic [YW-1:0]         fb_y_q, fb_y_d;
  logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
  logic                  de_prev_q, vs_prev_q;

  logic vs_start, de_fall, in_window;

  assign vs_start  = (vid_vs == VS_ACTIVE) && (vs_prev_q != VS_ACTIVE);
  assign de_fall   = de_prev_q && !vid_de;
  assign in_window = (fb_x_q < X_END) && (fb_y_q < Y_END);

  assign fb_rd_en   = vid_de && in_window;
  assign fb_rd_addr = row_base_q + ADDR_WIDTH'(fb_x_q);

  // Frame restart wins over everything, including a coincident end of line.
  always_comb begin
    h_sub_d    = h_sub_q;
    fb_x_d     = fb_x_q;
    v_sub_d    = v_sub_q;
    fb_y_d     = fb_y_q;
    row_base_d = row_base_q;
    if (vs_start) begin
      h_sub_d    = '0;
      fb_x_d     = '0;
      v_sub_d    = '0;
      fb_y_d     = '0;
      row_base_d = '0;
    end else if (de_fall) begin
      h_sub_d = '0;
      fb_x_d  = '0;
      if (v_sub_q == V_LAST) begin
        v_sub_d = '0;
        if (fb_y_q < Y_END) begin
          fb_y_d     = fb_y_q + YW'(1);
          row_base_d = row_base_q + ROW_INC;
        end
      end else begin
        v_sub_d = v_sub_q + VW'(1);
      end
    end else if (vid_de) begin
      if (h_sub_q == H_LAST) begin
        h_sub_d = '0;
        if (fb_x_q < X_END) fb_x_d = fb_x_q + XW'(1);
      end else begin
        h_sub_d = h_sub_q + HW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_sub_q    <= '0;
      fb_x_q     <= '0;
      v_sub_q    <= '0;
      fb_y_q     <= '0;
      row_base_q <= '0;
      de_prev_q  <= 1'b0;
      vs_prev_q  <= 1'b0;
    end else begin
      h_sub_q    <= h_sub_d;
      fb_x_q     <= fb_x_d;
      v_sub_q    <= v_sub_d;
      fb_y_q     <= fb_y_d;
      row_base_q <= row_base_d;
      de_prev_q  <= vid_de;
      vs_prev_q  <= vid_vs;
    end
  end

  // Stage 1 runs in step with the RAM output register.
  logic de1_q, hs1_q, vs1_q, win1_q;
  logic out_de_q, out_hs_q, out_vs_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de1_q    <= 1'b0;
      hs1_q    <= 1'b0;
      vs1_q    <= 1'b0;
      win1_q   <= 1'b0;
      out_de_q <= 1'b0;
      out_hs_q <= 1'b0;
      out_vs_q <= 1'b0;
    end else begin
      de1_q    <= vid_de;
      hs1_q    <= vid_hs;
      vs1_q    <= vid_vs;
      win1_q   <= in_window;
      out_de_q <= de1_q;
      out_hs_q <= hs1_q;
      out_vs_q <= vs1_q;
    end
  end

  assign out_de = out_de_q;
  assign out_hs = out_hs_q;
  assign out_vs = out_vs_q;

  rgb332_expand u_expand (
    .clk    (clk),
    .rst_n  (rst_n),
    .data_i (fb_rd_data),
    .en_i   (de1_q && win1_q),
    .r_o    (out_r),
    .g_o    (out_g),
    .b_o    (out_b)
  );

endmodule

// File: tb/tb_fb_scanout.sv
// Randomized line/frame stimulus for fb_scanout against a pixel-coordinate reference model,
// with scoreboard queues for the read port and the delayed video output.
module tb_fb_scanout;
  import video_pkg::*;

  localparam int  FW     = VID_FB_W;
  localparam int  FH     = VID_FB_H;
  localparam int  HS     = VID_H_SCALE;
  localparam int  VS     = VID_V_SCALE;
  localparam bit  VS_ACT = 1'b1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vid_de = 1'b0, vid_hs = 1'b0, vid_vs = 1'b0;
  logic        fb_rd_en;
  logic [14:0] fb_rd_addr;
  logic [7:0]  fb_rd_data = 8'h00;
  logic        out_de, out_hs, out_vs;
  logic [7:0]  out_r, out_g, out_b;

  always #5 clk = ~clk;

  fb_scanout dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .vid_de     (vid_de),
    .vid_hs     (vid_hs),
    .vid_vs     (vid_vs),
    .fb_rd_en   (fb_rd_en),
    .fb_rd_addr (fb_rd_addr),
    .fb_rd_data (fb_rd_data),
    .out_de     (out_de),
    .out_hs     (out_hs),
    .out_vs     (out_vs),
    .out_r      (out_r),
    .out_g      (out_g),
    .out_b      (out_b)
  );

  // Framebuffer RAM model: mem[a] = a[7:0], one-cycle registered read.
  logic [7:0] mem [VID_FB_DEPTH];
  initial for (int a = 0; a < VID_FB_DEPTH; a++) mem[a] = a[7:0];
  always @(posedge clk) if (fb_rd_en) fb_rd_data <= mem[fb_rd_addr];

  typedef struct {
    bit chk_rgb;
    bit de, hs, vs;
    int r, g, b;
  } out_exp_t;

  typedef struct {
    bit chk_en;
    bit en;
    bit chk_addr;
    int addr;
  } rd_exp_t;

  out_exp_t exp_q[$];
  rd_exp_t  rd_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference colour expansion: scale each channel to 0..255 with rounding.
  function automatic void ref_rgb(input int d, output int r, output int g, output int b);
    int rr, gg, bb;
    rr = d / 32;
    gg = (d / 4) % 8;
    bb = d % 4;
    r = (rr * 255 + 3) / 7;
    g = (gg * 255 + 3) / 7;
    b = bb * 85;
  endfunction

  // Reference state: pixel index within the line and line index since frame start.
  int m_p = 0, m_l = 0;
  bit m_ok = 0, m_de_prev = 0, m_vs_prev = 0, rst_drv = 0;

  task automatic step(input bit de, input bit hs, input bit vs, input bit rst);
    out_exp_t oe;
    rd_exp_t  re;
    int x, y, addr;
    bit win, en, vs_start;
    @(negedge clk);
    if (rst && !rst_drv) begin
      exp_q.delete();
      oe = '{default: 0};
      exp_q.push_back(oe);
    end
    rst_drv = rst;
    rst_n   = !rst;
    vid_de  = de;
    vid_hs  = hs;
    vid_vs  = vs;
    if (rst) begin
      m_p = 0; m_l = 0; m_ok = 0; m_de_prev = 0; m_vs_prev = 0;
      oe = '{default: 0};
      oe.chk_rgb = 1;
      exp_q.push_back(oe);
      re = '{chk_en: 1, en: de, chk_addr: 1, addr: 0};
      rd_q.push_back(re);
      return;
    end
    vs_start = (vs == VS_ACT) && (m_vs_prev != VS_ACT);
    x    = m_p / HS;
    y    = m_l / VS;
    win  = (x < FW) && (y < FH);
    en   = de && win;
    addr = y * FW + x;
    re   = '{chk_en: m_ok, en: en, chk_addr: m_ok && en, addr: addr};
    rd_q.push_back(re);
    oe = '{default: 0};
    oe.chk_rgb = m_ok;
    oe.de = de; oe.hs = hs; oe.vs = vs;
    if (en) ref_rgb(addr % 256, oe.r, oe.g, oe.b);
    exp_q.push_back(oe);
    if (vs_start) begin
      m_p = 0; m_l = 0; m_ok = 1;
    end else if (m_de_prev && !de) begin
      m_p = 0; m_l++;
    end else if (de) begin
      m_p++;
    end
    m_de_prev = de;
    m_vs_prev = vs;
  endtask

  // Read-port monitor: combinational outputs settle shortly after inputs change.
  rd_exp_t re_m;
  always @(negedge clk) begin
    #2;
    if (rd_q.size() > 0) begin
      re_m = rd_q.pop_front();
      if (re_m.chk_en)   check("rd_en", int'(fb_rd_en), int'(re_m.en));
      if (re_m.chk_addr) check("rd_addr", int'(fb_rd_addr), re_m.addr);
    end
  end

  // Output monitor: output after edge n+1 belongs to the input driven for cycle n-... (two entries deep).
  out_exp_t oe_m;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() >= 2) begin
      oe_m = exp_q.pop_front();
      check("out_de", int'(out_de), int'(oe_m.de));
      check("out_hs", int'(out_hs), int'(oe_m.hs));
      check("out_vs", int'(out_vs), int'(oe_m.vs));
      if (oe_m.chk_rgb) begin
        check("out_r", int'(out_r), oe_m.r);
        check("out_g", int'(out_g), oe_m.g);
        check("out_b", int'(out_b), oe_m.b);
      end
    end
  end

  task automatic blank();
    int n, hp;
    n  = $urandom_range(8, 3);
    hp = $urandom_range(n - 2, 0);
    for (int j = 0; j < n; j++) step(0, (j >= hp) && (j < hp + 2), 0, 0);
  endtask

  task automatic line(input int len);
    for (int i = 0; i < len; i++) step(1, 0, 0, 0);
    blank();
  endtask

  task automatic vs_pulse();
    repeat (3) step(0, 0, 1, 0);
    repeat (3) step(0, 0, 0, 0);
  endtask

  // VS rises in the very cycle DE falls.
  task automatic line_then_vs(input int len);
    for (int i = 0; i < len; i++) step(1, 0, 0, 0);
    vs_pulse();
  endtask

  initial begin
    int len;
    repeat (3) step(0, 0, 0, 1);
    repeat (4) step(0, 0, 0, 0);

    // Full frame, including an over-long line and lines past the framebuffer height.
    vs_pulse();
    for (int l = 0; l < 722; l++) begin
      if (l < 7 || (l >= 714 && l < 720)) len = 1280;
      else if (l == 7)                    len = 1300;
      else                                len = $urandom_range(24, 1);
      line(len);
    end

    // Frame restarted after line 300.
    vs_pulse();
    for (int l = 0; l < 301; l++) line($urandom_range(24, 1));
    vs_pulse();
    for (int l = 0; l < 20; l++) line($urandom_range(40, 1));
    line_then_vs(30);
    for (int l = 0; l < 8; l++) line($urandom_range(60, 9));

    // Reset in the middle of an active line.
    for (int i = 0; i < 20; i++) step(1, 0, 0, 0);
    repeat (3) step(1, 0, 0, 1);
    for (int i = 0; i < 27; i++) step(1, 0, 0, 0);
    blank();
    line(30);
    line(30);
    vs_pulse();
    for (int l = 0; l < 10; l++) line($urandom_range(60, 1));

    repeat (4) step(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fb_scanout.md
# fb_scanout

Pixel-clock scan-out stage that sits directly downstream of the framebuffer RAM. It consumes video timing (DE/HSYNC/VSYNC) from the HDMI timing generator and produces the framebuffer read address and read enable, replicating each stored pixel H_SCALE times horizontally and V_SCALE times vertically. It takes the registered RGB332 read data, expands it to RGB888, and re-aligns it with the delayed sync/DE so the TMDS encoder receives a coherent 720p stream.

## Interface
Parameters:
- ADDR_WIDTH, 15, framebuffer address width
- FB_W, 160, framebuffer width in pixels
- FB_H, 120, framebuffer height in lines
- H_SCALE, 8, horizontal replication factor
- V_SCALE, 6, vertical replication factor
- VS_ACTIVE, 1, active level of vid_vs (a frame restarts on the transition into this level)

Ports:
- clk  in  1  pixel clock (74.25 MHz); the only clock
- rst_n  in  1  asynchronous, active-low reset
- vid_de  in  1  active-video enable from the timing generator
- vid_hs  in  1  horizontal sync from the timing generator
- vid_vs  in  1  vertical sync from the timing generator
- fb_rd_en  out  1  framebuffer read enable (combinational)
- fb_rd_addr  out  ADDR_WIDTH  framebuffer read address (combinational)
- fb_rd_data  in  8  RGB332 {R[2:0],G[2:0],B[1:0]} from the RAM, valid 1 cycle after the address
- out_de  out  1  delayed DE
- out_hs  out  1  delayed HSYNC
- out_vs  out  1  delayed VSYNC
- out_r, out_g, out_b  out  8 each  RGB888 pixel

## Operation
- Counters:
  - h_sub: 0..H_SCALE-1
  - fb_x: 0..FB_W
  - v_sub: 0..V_SCALE-1
  - fb_y: 0..FB_H
  - row_base: ADDR_WIDTH bits, equal to fb_y*FB_W and maintained by adding FB_W; no multiplier.
- in_window = (fb_x < FB_W) && (fb_y < FB_H).
- fb_rd_en = vid_de && in_window.
- fb_rd_addr = row_base + fb_x (truncated to ADDR_WIDTH).
- Each cycle with vid_de=1:
  - h_sub increments.
  - When h_sub reaches H_SCALE-1, h_sub returns to 0 and fb_x increments, saturating at FB_W.
- Falling edge of vid_de (end of an active line):
  - h_sub and fb_x clear to 0.
  - v_sub increments.
  - When v_sub reaches V_SCALE-1, v_sub returns to 0, fb_y increments (saturating at FB_H), and row_base += FB_W (only while fb_y < FB_H).
- Transition of vid_vs into VS_ACTIVE: all counters clear to 0. This takes priority over a simultaneous DE falling edge.
- Pixels outside the window (DE longer than FB_W*H_SCALE, or more lines than FB_H*V_SCALE): fb_rd_en=0 and the output pixel is black.
- RGB expansion (registered), with d = fb_rd_data:
  - out_r = {R,R,R[2:1]}
  - out_g = {G,G,G[2:1]}
  - out_b = {B,B,B,B}
- out_r/g/b are forced to 0 whenever the delayed DE or the delayed in_window is 0.

## Timing
- Total latency from vid_* to out_* is 2 cycles:
  - Cycle 0: address/enable presented.
  - Cycle 1: RAM output register holds the data; de/hs/vs/in_window are held in pipeline stage 1.
  - Cycle 2: out_* registers update.
- Reset values: out_de=0, out_hs=0, out_vs=0, out_r/g/b=0; all counters, the previous-DE register and the previous-VS register are 0.
- fb_rd_en/fb_rd_addr during reset follow the (cleared) counters, so the address is 0.
- Reset mid-frame: the pipeline empties immediately. Scan-out resumes correctly at the next VS transition into VS_ACTIVE; output before that transition is undefined but must not hang.
- No backpressure; the block runs at one pixel per clock continuously.

## Structure
- Shared package video_pkg: FB_W, FB_H, H_SCALE, V_SCALE and the default ADDR_WIDTH, so the RAM depth (FB_W*FB_H) and this block are derived from one source.
- One sub-module, rgb332_expand: the registered 8-bit to 3x8-bit expansion with blanking gate.
- The counter/address logic stays in fb_scanout.

## Test plan
- 1280x720 timing, RAM model with mem[a]=a[7:0]:
  - Line 0, pixels 0-7 read address 0; pixels 8-15 read address 1.
  - Lines 0-5 read addresses 0..159; line 6 starts at address 160.
  - Last line reads addresses 19040..19199.
- Data 8'hFF → RGB 255,255,255; 8'hE0 → 255,0,0; 8'h03 → 0,0,255; 8'h00 → 0,0,0.
- Latency and alignment: a DE edge, HS pulse or VS pulse at input cycle n appears on out_* at cycle n+2, aligned with the first expanded pixel.
- Over-long line (DE high for 1300 cycles): pixels 1280-1299 give fb_rd_en=0 and RGB 0. The next line starts at the correct row address.
- VS mid-frame after line 300: the next active line reads address 0. A DE falling edge in the same cycle as the VS transition still yields address 0.
- rst_n low for 3 cycles mid-line: all out_* read 0 within the reset. After release plus one VS transition, address 0 appears on the first DE cycle.
